// File: rtl/expand_state.sv
// Key-schedule sequencer for bcrypt ExpandState/Expand0State: folds the key into P, then
// drives 521 chained encryptions through feistel and writes each result pair over P and S1..S4.
module expand_state #(
  parameter int unsigned SALT_W = 128
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              start,
  input  logic              salt_en,
  input  logic [SALT_W-1:0] salt,
  input  logic [31:0]       key_out,
  output logic [4:0]        key_addr,
  output logic              key_cs_l,
  input  logic [31:0]       p_out,
  output logic [4:0]        p_addr,
  output logic [31:0]       p_in,
  output logic              p_cs_l,
  output logic              p_we_l,
  output logic              p_own,
  output logic [7:0]        s_addr,
  output logic [31:0]       s_in,
  output logic [3:0]        s_we_l,
  output logic              f_start,
  output logic [31:0]       f_L,
  output logic [31:0]       f_R,
  input  logic [31:0]       f_resultL,
  input  logic [31:0]       f_resultR,
  input  logic              f_done,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    StIdle,
    StKeyRd,
    StKeyW0,
    StKeyW1,
    StKeyWr,
    StEncStart,
    StEncWait,
    StWrL,
    StWrR,
    StDone
  } state_e;

  state_e            state_q;
  logic [4:0]        i_q;
  logic [9:0]        n_q;
  logic [31:0]       l_q;
  logic [31:0]       r_q;
  logic [SALT_W-1:0] sreg_q;
  logic              sen_q;

  logic        enc_odd;
  logic [31:0] salt_l;
  logic [31:0] salt_r;
  logic [31:0] enc_l;
  logic [31:0] enc_r;
  logic        wr_is_p;
  logic [8:0]  k;
  logic [3:0]  box_we_l;
  logic [4:0]  wr_p_base;
  logic [7:0]  wr_s_base;

  // Parity of the encryption about to be issued; leaving WR_R that is n+1.
  assign enc_odd  = (state_q == StWrR) ? ~n_q[0] : n_q[0];
  assign salt_l   = enc_odd ? sreg_q[SALT_W-65 -: 32] : sreg_q[SALT_W-1 -: 32];
  assign salt_r   = enc_odd ? sreg_q[SALT_W-97 -: 32] : sreg_q[SALT_W-33 -: 32];
  assign enc_l    = sen_q ? (l_q ^ salt_l) : l_q;
  assign enc_r    = sen_q ? (r_q ^ salt_r) : r_q;

  // Result pair n lands in P for n < 9, otherwise in S box k[8:7] at 2*k[6:0].
  assign wr_is_p   = (n_q < 10'd9);
  assign k         = n_q[8:0] - 9'd9;
  assign box_we_l  = ~(4'b0001 << k[8:7]);
  assign wr_p_base = {n_q[3:0], 1'b0};
  assign wr_s_base = {k[6:0], 1'b0};

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= StIdle;
      i_q      <= '0;
      n_q      <= '0;
      l_q      <= '0;
      r_q      <= '0;
      sreg_q   <= '0;
      sen_q    <= 1'b0;
      key_addr <= '0;
      key_cs_l <= 1'b1;
      p_addr   <= '0;
      p_in     <= '0;
      p_cs_l   <= 1'b1;
      p_we_l   <= 1'b1;
      p_own    <= 1'b0;
      s_addr   <= '0;
      s_in     <= '0;
      s_we_l   <= 4'hF;
      f_start  <= 1'b0;
      f_L      <= '0;
      f_R      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      key_cs_l <= 1'b1;
      p_cs_l   <= 1'b1;
      p_we_l   <= 1'b1;
      s_we_l   <= 4'hF;
      p_own    <= 1'b0;
      f_start  <= 1'b0;
      done     <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            sreg_q   <= salt;
            sen_q    <= salt_en;
            i_q      <= '0;
            n_q      <= '0;
            l_q      <= '0;
            r_q      <= '0;
            busy     <= 1'b1;
            key_addr <= '0;
            p_addr   <= '0;
            key_cs_l <= 1'b0;
            p_cs_l   <= 1'b0;
            p_own    <= 1'b1;
            state_q  <= StKeyRd;
          end
        end
        StKeyRd: begin
          p_own   <= 1'b1;
          state_q <= StKeyW0;
        end
        StKeyW0: begin
          p_own   <= 1'b1;
          state_q <= StKeyW1;
        end
        StKeyW1: begin
          // p_in doubles as the holding register for the XORed word.
          p_in    <= p_out ^ key_out;
          p_cs_l  <= 1'b0;
          p_we_l  <= 1'b0;
          p_own   <= 1'b1;
          state_q <= StKeyWr;
        end
        StKeyWr: begin
          if (i_q == 5'd17) begin
            f_start <= 1'b1;
            f_L     <= enc_l;
            f_R     <= enc_r;
            state_q <= StEncStart;
          end else begin
            i_q      <= i_q + 5'd1;
            key_addr <= i_q + 5'd1;
            p_addr   <= i_q + 5'd1;
            key_cs_l <= 1'b0;
            p_cs_l   <= 1'b0;
            p_own    <= 1'b1;
            state_q  <= StKeyRd;
          end
        end
        StEncStart: begin
          state_q <= StEncWait;
        end
        StEncWait: begin
          if (f_done) begin
            l_q <= f_resultL;
            r_q <= f_resultR;
            if (wr_is_p) begin
              p_addr <= wr_p_base;
              p_in   <= f_resultL;
              p_cs_l <= 1'b0;
              p_we_l <= 1'b0;
              p_own  <= 1'b1;
            end else begin
              s_addr <= wr_s_base;
              s_in   <= f_resultL;
              s_we_l <= box_we_l;
            end
            state_q <= StWrL;
          end
        end
        StWrL: begin
          if (wr_is_p) begin
            p_addr <= wr_p_base | 5'd1;
            p_in   <= r_q;
            p_cs_l <= 1'b0;
            p_we_l <= 1'b0;
            p_own  <= 1'b1;
          end else begin
            s_addr <= wr_s_base | 8'd1;
            s_in   <= r_q;
            s_we_l <= box_we_l;
          end
          state_q <= StWrR;
        end
        StWrR: begin
          if (n_q == 10'd520) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            n_q     <= n_q + 10'd1;
            f_start <= 1'b1;
            f_L     <= enc_l;
            f_R     <= enc_r;
            state_q <= StEncStart;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_expand_state.sv
// Scoreboarded bench for expand_state with SRAM and feistel behavioural models.
module tb_expand_state;

  localparam int NENC = 521;

  logic         clk = 1'b0;
  logic         reset_l = 1'b0;
  logic         start_main = 1'b0;
  logic         start_glitch = 1'b0;
  logic         start;
  logic         salt_en = 1'b0;
  logic [127:0] salt = '0;
  logic [31:0]  key_out = '0;
  logic [31:0]  p_out = '0;
  logic [4:0]   key_addr, p_addr;
  logic         key_cs_l, p_cs_l, p_we_l, p_own;
  logic [7:0]   s_addr;
  logic [31:0]  p_in, s_in, f_L, f_R;
  logic [3:0]   s_we_l;
  logic         f_start, busy, done;
  logic         f_done = 1'b0;
  logic [31:0]  f_resultL = '0;
  logic [31:0]  f_resultR = '0;

  assign start = start_main | start_glitch;

  expand_state #(.SALT_W(128)) dut (
    .clk(clk), .reset_l(reset_l), .start(start), .salt_en(salt_en), .salt(salt),
    .key_out(key_out), .key_addr(key_addr), .key_cs_l(key_cs_l),
    .p_out(p_out), .p_addr(p_addr), .p_in(p_in), .p_cs_l(p_cs_l), .p_we_l(p_we_l),
    .p_own(p_own), .s_addr(s_addr), .s_in(s_in), .s_we_l(s_we_l),
    .f_start(f_start), .f_L(f_L), .f_R(f_R), .f_resultL(f_resultL), .f_resultR(f_resultR),
    .f_done(f_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_p;
    logic [1:0]  box;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] key_mem [32];
  logic [31:0] p_mem   [32];
  logic [31:0] s_mem   [4][256];
  logic [31:0] exp_p   [18];
  logic [31:0] exp_s   [4][256];
  logic [31:0] init_p  [18];
  logic [31:0] img_p   [18];
  logic [31:0] img_s   [4][256];

  wr_t         exp_wr[$];
  logic [63:0] exp_f[$];
  logic [31:0] obs_fl[$];
  logic [31:0] obs_fr[$];

  int     n_tests = 0;
  int     n_fail = 0;
  int     fstart_cnt = 0;
  int     viol_cnt = 0;
  longint tf_sum = 0;

  // Feistel model configuration: 0 = (L+1, R+2), 1 = identity.
  int f_func = 0;
  bit tf_rand = 1'b0;
  int tf_fixed = 54;
  bit tf_glitch = 1'b0;

  bit          mon_in_wait = 1'b0;
  logic [63:0] mon_held = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ffun(input logic [31:0] a, input logic [31:0] b);
    if (f_func == 0) return {a + 32'd1, b + 32'd2};
    return {a, b};
  endfunction

  function automatic wr_t mk_wr(input bit is_p, input int box, input int addr,
                                input logic [31:0] d);
    wr_t w;
    w.is_p = is_p;
    w.box  = box[1:0];
    w.addr = addr[7:0];
    w.data = d;
    return w;
  endfunction

  // Reference: key XOR, then 521 chained encryptions written P[0..17], S1[0]..S4[255].
  task automatic build_expect();
    logic [31:0] l, r, il, ir;
    logic [63:0] res;
    int kk, bx, ad;
    exp_wr.delete();
    exp_f.delete();
    for (int i = 0; i < 18; i++) begin
      exp_p[i] = p_mem[i] ^ key_mem[i];
      exp_wr.push_back(mk_wr(1'b1, 0, i, exp_p[i]));
    end
    l = '0;
    r = '0;
    for (int n = 0; n < NENC; n++) begin
      il = l;
      ir = r;
      if (salt_en) begin
        if (n % 2 == 0) begin
          il = il ^ salt[127:96];
          ir = ir ^ salt[95:64];
        end else begin
          il = il ^ salt[63:32];
          ir = ir ^ salt[31:0];
        end
      end
      exp_f.push_back({il, ir});
      res = ffun(il, ir);
      l = res[63:32];
      r = res[31:0];
      if (n < 9) begin
        exp_p[2*n]   = l;
        exp_p[2*n+1] = r;
        exp_wr.push_back(mk_wr(1'b1, 0, 2*n, l));
        exp_wr.push_back(mk_wr(1'b1, 0, 2*n+1, r));
      end else begin
        kk = n - 9;
        bx = kk / 128;
        ad = 2 * (kk % 128);
        exp_s[bx][ad]   = l;
        exp_s[bx][ad+1] = r;
        exp_wr.push_back(mk_wr(1'b0, bx, ad, l));
        exp_wr.push_back(mk_wr(1'b0, bx, ad + 1, r));
      end
    end
  endtask

  // SRAMs: read data valid two cycles after the chip-select cycle, garbage otherwise.
  initial begin : sram_model
    logic [31:0] kd1, kd2, pd1, pd2;
    logic        kv1, kv2, pv1, pv2;
    kv1 = 1'b0; kv2 = 1'b0; pv1 = 1'b0; pv2 = 1'b0;
    kd1 = '0; kd2 = '0; pd1 = '0; pd2 = '0;
    forever begin
      @(negedge clk);
      key_out = kv2 ? kd2 : $urandom;
      p_out   = pv2 ? pd2 : $urandom;
      kv2 = kv1; kd2 = kd1;
      pv2 = pv1; pd2 = pd1;
      kv1 = !key_cs_l;
      kd1 = key_mem[key_addr];
      pv1 = !p_cs_l && p_we_l;
      pd1 = p_mem[p_addr];
      if (!p_cs_l && !p_we_l) p_mem[p_addr] = p_in;
      for (int b = 0; b < 4; b++) if (!s_we_l[b]) s_mem[b][s_addr] = s_in;
    end
  end

  initial begin : feistel_model
    logic [31:0] a, b;
    logic [63:0] res;
    int d;
    forever begin
      @(negedge clk);
      if (f_start && reset_l) begin
        a = f_L;
        b = f_R;
        d = tf_rand ? int'($urandom_range(80, 1)) : tf_fixed;
        tf_sum += d;
        for (int c = 1; c <= d; c++) begin
          @(negedge clk);
          start_glitch = tf_glitch && (c == 1) && (d >= 2);
        end
        start_glitch = 1'b0;
        res = ffun(a, b);
        f_resultL = res[63:32];
        f_resultR = res[31:0];
        f_done = 1'b1;
        @(negedge clk);
        if (tf_glitch) begin
          f_resultL = ~a;
          f_resultR = ~b;
          @(negedge clk);
        end
        f_done = 1'b0;
      end
    end
  end

  task automatic check_write();
    wr_t g, e;
    bit  p_wr;
    int  ns;
    p_wr = !p_cs_l && !p_we_l;
    ns = $countones(~s_we_l);
    check("single write strobe", 64'(ns + (p_wr ? 1 : 0)), 64'd1);
    g.is_p = p_wr;
    g.box  = 2'd0;
    if (!p_wr) for (int b = 0; b < 4; b++) if (!s_we_l[b]) g.box = 2'(b);
    g.addr = p_wr ? {3'b000, p_addr} : s_addr;
    g.data = p_wr ? p_in : s_in;
    if (exp_wr.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected write: got %0h, expected no write", g);
    end else begin
      e = exp_wr.pop_front();
      check("sram write/p_own", {g, p_own}, {e, e.is_p});
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (!reset_l) begin
        mon_in_wait = 1'b0;
      end else begin
        if (mon_in_wait && (p_own || !p_cs_l || !key_cs_l || s_we_l != 4'hF ||
                            {f_L, f_R} != mon_held)) viol_cnt++;
        if (f_done) mon_in_wait = 1'b0;
        if (f_start) begin
          fstart_cnt++;
          mon_in_wait = 1'b1;
          mon_held = {f_L, f_R};
          obs_fl.push_back(f_L);
          obs_fr.push_back(f_R);
          if (exp_f.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected f_start: got %0h, expected none", {f_L, f_R});
          end else begin
            check("f_L/f_R", {f_L, f_R}, exp_f.pop_front());
          end
        end
        if ((!p_cs_l && !p_we_l) || s_we_l != 4'hF) check_write();
      end
    end
  end

  task automatic do_run(input string tag, output int cyc);
    longint tf0;
    int     fs0, v0, mism;
    bit     seen;
    build_expect();
    tf0 = tf_sum;
    fs0 = fstart_cnt;
    v0  = viol_cnt;
    @(negedge clk);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    cyc = 1;
    seen = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    while (!seen && cyc < 40000) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " done reached"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(72 + 3 * NENC + (tf_sum - tf0) + 1));
    check({tag, " busy at done"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({tag, " done/busy after"}, {62'd0, done, busy}, 64'd0);
    check({tag, " f_start pulses"}, 64'(fstart_cnt - fs0), 64'(NENC));
    check({tag, " leftover expected"}, 64'(exp_wr.size() + exp_f.size()), 64'd0);
    mism = 0;
    for (int i = 0; i < 18; i++) if (p_mem[i] !== exp_p[i]) mism++;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) if (s_mem[b][a] !== exp_s[b][a]) mism++;
    check({tag, " image mismatches"}, 64'(mism), 64'd0);
    check({tag, " enc_wait violations"}, 64'(viol_cnt - v0), 64'd0);
  endtask

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc, base, w, mism;
    for (int i = 0; i < 32; i++) begin
      key_mem[i] = '0;
      p_mem[i] = '0;
    end
    for (int b = 0; b < 4; b++) for (int a = 0; a < 256; a++) s_mem[b][a] = '0;

    repeat (3) @(negedge clk);
    check("reset strobes", {53'd0, key_cs_l, p_cs_l, p_we_l, s_we_l, f_start, done, busy, p_own},
          64'b111_1111_0000);
    check("reset addresses", {46'd0, key_addr, p_addr, s_addr}, 64'd0);
    check("reset p_in/s_in", {p_in, s_in}, 64'd0);
    check("reset f_L/f_R", {f_L, f_R}, 64'd0);
    reset_l = 1'b1;

    // A: identity P, key A5.., (L+1,R+2), unsalted, T_f=54.
    for (int i = 0; i < 18; i++) begin
      key_mem[i] = 32'hA5A5A5A5;
      p_mem[i] = 32'(i);
    end
    f_func = 0; tf_rand = 1'b0; tf_fixed = 54; tf_glitch = 1'b0; salt_en = 1'b0;
    do_run("A", cyc);
    check("A absolute latency", 64'(cyc), 64'd29770);
    check("A P[0],P[1]", {p_mem[0], p_mem[1]}, {32'd1, 32'd2});
    check("A P[2],P[3]", {p_mem[2], p_mem[3]}, {32'd2, 32'd4});
    check("A S4[254],S4[255]", {s_mem[3][254], s_mem[3][255]}, {32'd521, 32'd1042});

    // B: salted identity, short T_f, stray start in ENC_WAIT and stray f_done in WR_L.
    salt = 128'h11111111_22222222_33333333_44444444;
    salt_en = 1'b1; f_func = 1; tf_fixed = 4; tf_glitch = 1'b1;
    base = obs_fl.size();
    do_run("B", cyc);
    check("B first f_L/f_R", {obs_fl[base], obs_fr[base]}, 64'h11111111_22222222);
    check("B second f_L/f_R", {obs_fl[base+1], obs_fr[base+1]}, 64'h22222222_66666666);
    tf_glitch = 1'b0;

    // C: random data and random T_f, then the same data with fixed T_f.
    for (int i = 0; i < 18; i++) begin
      key_mem[i] = $urandom;
      init_p[i] = $urandom;
      p_mem[i] = init_p[i];
    end
    salt = {$urandom, $urandom, $urandom, $urandom};
    salt_en = 1'b1; f_func = 0; tf_rand = 1'b1;
    do_run("C", cyc);
    for (int i = 0; i < 18; i++) img_p[i] = p_mem[i];
    for (int b = 0; b < 4; b++) for (int a = 0; a < 256; a++) img_s[b][a] = s_mem[b][a];
    for (int i = 0; i < 18; i++) p_mem[i] = init_p[i];
    tf_rand = 1'b0; tf_fixed = 3;
    do_run("C2", cyc);
    mism = 0;
    for (int i = 0; i < 18; i++) if (p_mem[i] !== img_p[i]) mism++;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) if (s_mem[b][a] !== img_s[b][a]) mism++;
    check("C vs C2 image differences", 64'(mism), 64'd0);

    // D: reset while writing S for n=300, then a full run.
    for (int i = 0; i < 18; i++) begin
      key_mem[i] = $urandom;
      init_p[i] = $urandom;
      p_mem[i] = init_p[i];
    end
    salt = {$urandom, $urandom, $urandom, $urandom};
    tf_fixed = 2;
    build_expect();
    base = fstart_cnt;
    @(negedge clk);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    w = 0;
    while (fstart_cnt - base < 301 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    w = 0;
    while (s_we_l == 4'hF && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("D n=300 S write", {52'd0, s_we_l, s_addr}, {52'd0, 4'b1011, 8'd70});
    #2;
    reset_l = 1'b0;
    #1;
    check("D strobes in reset", {56'd0, key_cs_l, p_cs_l, p_we_l, s_we_l[0], f_start, done,
          busy, p_own}, 64'b1111_0000);
    check("D s_we_l in reset", 64'(s_we_l), 64'hF);
    repeat (3) @(negedge clk);
    exp_wr.delete();
    exp_f.delete();
    for (int i = 0; i < 18; i++) p_mem[i] = init_p[i];
    reset_l = 1'b1;
    do_run("D", cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
